// File: rtl/sweep_pkg.sv
// Shared types and sizing helpers for the operand sweep generator.
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam int unsigned SWEEP_BITS_DEF = 4;
  localparam int unsigned CNT_W          = 3 * SWEEP_BITS_DEF + 1;

  // Number of patterns in one complete sweep of three digits.
  function automatic longint unsigned total_patterns(input int unsigned sweep_bits);
    return 64'(1) << (3 * sweep_bits);
  endfunction

  // Count width with one spare bit so a full sweep never wraps.
  function automatic int unsigned cnt_width(input int unsigned sweep_bits);
    return 3 * sweep_bits + 1;
  endfunction

endpackage

// File: rtl/sweep_digit.sv
// One digit of the sweep: clearable wrap-around counter with a ripple carry.
module sweep_digit
  import sweep_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         carry_out
);

  localparam logic [W-1:0] DIGIT_MAX = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= value + W'(1);
    end
  end

  // Carry fires on the increment that wraps this digit back to zero.
  assign carry_out = inc && (value == DIGIT_MAX);

endmodule

// File: rtl/operand_sweep_gen.sv
// Exhaustive (in1, in2, in3) sweep generator with valid/ready handshake,
// abort, accepted-pattern counter and a last-pattern flag.
module operand_sweep_gen
  import sweep_pkg::*;
#(
  parameter int unsigned IN_W       = 19,
  parameter int unsigned SWEEP_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  ready,
  output logic [IN_W-1:0]       in1,
  output logic [IN_W-1:0]       in2,
  output logic [IN_W-1:0]       in3,
  output logic                  valid,
  output logic                  last,
  output logic                  busy,
  output logic                  done,
  output logic [3*SWEEP_BITS:0] pattern_count
);

  localparam int unsigned CW = cnt_width(SWEEP_BITS);

  state_e                state;
  logic [SWEEP_BITS-1:0] d1, d2, d3;
  logic                  c3, c2, carry_unused;
  logic                  all_max;
  logic                  clr;
  logic                  adv;
  logic                  accept;

  assign all_max = (&d1) && (&d2) && (&d3);
  assign last    = valid && all_max;
  assign accept  = (state == RUN) && !abort && valid && ready;

  // Digits clear on sweep start and step on every non-final acceptance.
  assign clr = (state == IDLE) && start;
  assign adv = accept && !all_max;

  sweep_digit #(.W(SWEEP_BITS)) u_d3 (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .inc       (adv),
    .value     (d3),
    .carry_out (c3)
  );

  sweep_digit #(.W(SWEEP_BITS)) u_d2 (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .inc       (c3),
    .value     (d2),
    .carry_out (c2)
  );

  sweep_digit #(.W(SWEEP_BITS)) u_d1 (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .inc       (c2),
    .value     (d1),
    .carry_out (carry_unused)
  );

  assign in1 = IN_W'(d1);
  assign in2 = IN_W'(d2);
  assign in3 = IN_W'(d3);

  // Sweep control; done is raised on entry to FIN so it pulses the cycle after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      valid         <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pattern_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state         <= RUN;
            valid         <= 1'b1;
            busy          <= 1'b1;
            pattern_count <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            state <= FIN;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (valid && ready) begin
            pattern_count <= pattern_count + CW'(1);
            if (all_max) begin
              state <= FIN;
              valid <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/operand_sweep_gen.md
Name: operand_sweep_gen

Overview:
- Upstream stimulus stage for the 3-operand `top` datapath (in1/in2/in3 → out1).
- Generates an exhaustive nested sweep of (in1, in2, in3), each over 0..2^SWEEP_BITS-1, in that nesting order with in3 fastest.
- Drives the operands through a valid/ready handshake so a downstream capture or checker stage can stall it.
- Counts accepted patterns and flags the final one, so a full sweep replaces hand-written nested loops.

Parameters:
- IN_W, 19, width of each operand output; matches top's in1/in2/in3.
- SWEEP_BITS, 4, bits swept per operand; each operand covers 0..2^SWEEP_BITS-1. Constraint: 1 ≤ SWEEP_BITS ≤ IN_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; sampled only in IDLE.
- abort  in  1  terminates a running sweep; has priority over the handshake.
- ready  in  1  downstream accepts the current pattern when valid && ready.
- in1  out  IN_W  operand 1, the slowest-moving digit, zero-extended.
- in2  out  IN_W  operand 2, the middle digit, zero-extended.
- in3  out  IN_W  operand 3, the fastest-moving digit, zero-extended.
- valid  out  1  the current operands are a live pattern.
- last  out  1  the current pattern is (max, max, max); qualified by valid.
- busy  out  1  FSM is in RUN.
- done  out  1  one-cycle pulse after the last pattern is accepted or after an abort.
- pattern_count  out  3*SWEEP_BITS+1  number of patterns accepted in the current or most recent sweep.

Behaviour:
- Reset (asynchronous, active-high):
  - in1 = in2 = in3 = 0; valid = last = busy = done = 0; pattern_count = 0; state = IDLE.
  - Reset asserted mid-sweep abandons the sweep immediately; no done pulse is produced.
- FSM states: IDLE, RUN, FIN.
  - IDLE → RUN when start = 1. On that edge: digits cleared to 0, pattern_count cleared to 0, valid goes to 1. The first pattern (0,0,0) is valid on the cycle after start (1-cycle latency).
  - RUN, valid && ready && !last: advance one step. Digit d3 increments; on wrap from max to 0 it carries into d2; d2 carries into d1 the same way. pattern_count += 1.
  - RUN, valid && ready && last: pattern_count += 1, valid → 0, state → FIN.
  - RUN, ready = 0: operands, valid, last and pattern_count all hold. Operands must be stable while valid && !ready.
  - RUN, abort = 1: state → FIN and valid → 0 regardless of ready. A pattern presented in that same cycle is not counted.
  - FIN: done = 1 for exactly one cycle, then state → IDLE. pattern_count holds until the next start.
- start is ignored in RUN and FIN. abort is ignored in IDLE and FIN.
- last is combinational from the registered digits: (d1 == max) && (d2 == max) && (d3 == max) && valid.
- busy = (state == RUN).
- Operand outputs are {(IN_W-SWEEP_BITS) zeros, digit}. After the final acceptance the digits hold their last value (all max); they are not cleared.
- A complete sweep produces exactly 2^(3*SWEEP_BITS) accepted patterns, giving pattern_count = 4096 at default parameters. The count never wraps because its width carries one spare bit.
- Throughput: one pattern per cycle while ready is held high.

Decomposition:
- Shared package sweep_pkg holds:
  - the state enum {IDLE, RUN, FIN};
  - function total_patterns(SWEEP_BITS) = 2^(3*SWEEP_BITS);
  - localparam CNT_W = 3*SWEEP_BITS + 1.
- Natural sub-module: sweep_digit, a SWEEP_BITS-wide counter with clr, inc and carry_out. It is instantiated three times and chained through carry_out → inc.
- The FSM, handshake logic and pattern_count stay in operand_sweep_gen.

Test Plan (all at default parameters):
1. Reset mid-sweep. Assert rst after 37 accepts → all outputs 0 within the same cycle (asynchronous); no done pulse; a later start re-sweeps from (0,0,0).
2. Full sweep with ready held at 1. Pulse start → valid rises on the next cycle with (0,0,0). Patterns arrive in order (0,0,1), (0,0,2) … (0,0,15), (0,1,0) … (15,15,15), one per cycle. last is high only on (15,15,15). done pulses exactly one cycle after that acceptance. pattern_count = 4096.
3. Backpressure. Drop ready for 5 cycles while (2,7,15) is presented → operands and pattern_count hold. The next accepted pattern after ready returns is (2,8,0).
4. Abort. Assert abort during pattern (3,0,4), with 772 patterns already accepted → valid = 0 on the next cycle, done pulses once, pattern_count = 772.
5. start while busy. Pulse start at pattern (1,1,1) → no restart; the sweep continues to (1,1,2); the final pattern_count is still 4096.
6. Random ready. Toggle ready at roughly 50% → the downstream scoreboard sees all 4096 tuples, each exactly once and in order; last is asserted only with valid.
